mac_operand_feeder: RTL
=======================

# mac_operand_feeder

Upstream operand stage for the 512-bit CLA multiply-accumulate block. Accepts a narrow valid/ready word stream, assembles 128-bit A and B operands, and presents each pair to the MAC with a one-cycle enable pulse. The MAC's product is registered one enable later than its operands. At the end of a frame the feeder therefore issues one extra zero-operand flush enable so the last product reaches the accumulator, then reports frame completion.

## Interface
- DATA_W, 32, input word width; must divide OP_W evenly.
- OP_W, 128, operand width; matches the MAC A_in/B_in width.
- CNT_W, 16, width of the pair counter.

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- s_valid  in  1  input word valid
- s_ready  out  1  feeder can accept a word
- s_data  in  DATA_W  input word
- s_last  in  1  marks the final B word of a frame
- mac_en  out  1  enable pulse to MAC
- a_out  out  OP_W  operand A to MAC A_in
- b_out  out  OP_W  operand B to MAC B_in
- done  out  1  one-cycle pulse; frame fully accumulated
- pair_cnt  out  CNT_W  pairs issued in the current or just-finished frame
- proto_err  out  1  sticky; s_last seen on a word other than the final B word

## Operation
- WORDS = OP_W/DATA_W.
- Word transfer occurs when s_valid && s_ready at a rising edge.
- Word order within an operand: first beat is the least significant word. Beat k fills bits [k*DATA_W +: DATA_W].
- State machine:
  - LOAD_A
    - s_ready=1.
    - Collects WORDS beats into the A holding register.
    - After the final beat, goes to LOAD_B.
  - LOAD_B
    - s_ready=1.
    - Collects WORDS beats into the B holding register.
    - The final beat samples s_last into last_q.
    - Then goes to ISSUE.
  - ISSUE
    - s_ready=0, mac_en=1.
    - a_out/b_out carry the assembled pair.
    - pair_cnt increments.
    - Next state is FLUSH if last_q, else LOAD_A.
  - FLUSH
    - s_ready=0, mac_en=1, a_out=b_out=0.
    - Goes to DONE.
  - DONE
    - s_ready=0, done=1.
    - pair_cnt holds the frame total.
    - Goes to LOAD_A.
    - pair_cnt clears to 0 on the first accepted beat of the next frame.
- a_out/b_out are registered. They update only on entry to ISSUE (the assembled pair) or FLUSH (zero), and hold otherwise.
- One word counter, 0..WORDS-1, is shared by both load states and wraps to 0 on each state change.
- s_last on any beat other than the final B beat: the beat is accepted normally, s_last is ignored, and proto_err is set. proto_err clears only on reset.
- pair_cnt saturates at all-ones; it does not wrap.
- The feeder never clears the MAC accumulator. Frame-level accumulator clearing is the system's responsibility via the MAC reset.

## Timing
- Reset (rst_n=0 at a rising edge), values from the next cycle:
  - state=LOAD_A, word counter=0, last_q=0.
  - s_ready=1.
  - mac_en=0, done=0.
  - a_out=0, b_out=0, pair_cnt=0, proto_err=0.
  - Partially assembled operands are discarded.
- Reset asserted mid-frame, including during ISSUE or FLUSH, aborts the frame:
  - no further mac_en;
  - no done pulse.
- Final B beat accepted at edge T:
  - ISSUE during cycle T..T+1, so mac_en is high for exactly one cycle.
  - If not last, s_ready returns high from edge T+1.
  - If last: FLUSH at T+1, DONE at T+2, s_ready high from T+3.
- Throughput with s_valid held high: one pair per 2*WORDS+1 cycles. Each frame adds 2 cycles.
- s_ready depends only on state, never on s_valid; there is no combinational path from s_valid to s_ready.
- mac_en is never high in two consecutive cycles, except ISSUE followed by FLUSH.

## Structure
- Shared package mac_pkg holds:
  - the state enum (ST_LOAD_A, ST_LOAD_B, ST_ISSUE, ST_FLUSH, ST_DONE);
  - OP_W and the derived WORDS localparam, used jointly by this block and the MAC.
- One natural sub-module, word_packer: counter plus indexed write into an OP_W register, instantiated twice (A and B).
- The FSM stays in the top module.

## Test plan
- Single-pair frame, DATA_W=32:
  - Stimulus: A words 1,2,3,4; B words 5,6,7,8 with s_last on the 8th beat.
  - Required response:
    - a_out=128'h00000004_00000003_00000002_00000001 with mac_en;
    - next cycle mac_en with zeros;
    - done one cycle later with pair_cnt=1.
  - The MAC model's accumulator must equal A*B.
- Three-pair frame with s_valid held high:
  - Required response: exactly 4 mac_en pulses (3 ISSUE + 1 FLUSH), done with pair_cnt=3, accumulator equals the sum of the three products.
  - The ISSUE pulses are 9 cycles apart.
- Backpressure and gaps:
  - Stimulus: random s_valid deassertion.
  - Required response: data order is preserved and a_out/b_out are unchanged between issues. s_ready is low during ISSUE, FLUSH and DONE, and no beat is accepted then.
- Protocol error:
  - Stimulus: s_last on the 2nd A beat.
  - Required response: proto_err=1 and stays set; the frame continues. done fires only after a correct final-B s_last.
- Reset mid-LOAD_B:
  - Stimulus: sync reset after 2 B beats.
  - Required response: all outputs match reset values next cycle and no mac_en occurs. A fresh pair then assembles correctly from beat 0.
- Parameter DATA_W=64:
  - Stimulus: a two-beat operand with words 64'hA, 64'hB.
  - Required response: a_out=128'h000000000000000B_000000000000000A, and ISSUE follows the 4th total beat.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC definitions: operand width, beat count and the feeder state encoding.
`default_nettype none

package mac_pkg;

   localparam int OP_W  = 128;
   localparam int WORDS = OP_W / 32;

   typedef enum logic [2:0] {
      ST_LOAD_A = 3'd0,
      ST_LOAD_B = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_FLUSH  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/word_packer.sv
// Assembles DATA_W beats, least significant word first, into an OP_W holding register.
`default_nettype none

module word_packer #(
   parameter int DATA_W = 32,
   parameter int OP_W   = mac_pkg::OP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] data_in,
   output logic              final_beat,
   output logic [OP_W-1:0]   data_out
);

   localparam int BEATS = OP_W / DATA_W;
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [IDX_W-1:0] idx;
   logic [OP_W-1:0]  data_q;

   assign final_beat = (idx == IDX_W'(BEATS - 1));

   // data_out already includes a beat being written this cycle, so the
   // owner can capture a complete operand on the final beat's edge.
   always_comb begin
      data_out = data_q;
      if (load)
         data_out[int'(idx)*DATA_W +: DATA_W] = data_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx    <= '0;
         data_q <= '0;
      end else if (load) begin
         data_q <= data_out;
         idx    <= final_beat ? '0 : idx + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mac_operand_feeder.sv
// Collects A/B operand pairs from a word stream and issues them to the MAC,
// appending a zero-operand flush enable at the end of each frame.
`default_nettype none

module mac_operand_feeder #(
   parameter int DATA_W = 32,
   parameter int OP_W   = mac_pkg::OP_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              mac_en,
   output logic [OP_W-1:0]   a_out,
   output logic [OP_W-1:0]   b_out,
   output logic              done,
   output logic [CNT_W-1:0]  pair_cnt,
   output logic              proto_err
);

   import mac_pkg::*;

   state_t state;
   state_t state_nxt;

   logic            beat;
   logic            a_load;
   logic            b_load;
   logic            a_final;
   logic            b_final;
   logic            b_done_beat;
   logic [OP_W-1:0] a_view;
   logic [OP_W-1:0] b_view;
   logic            last_q;
   logic            frame_closed;

   assign beat        = s_valid && s_ready;
   assign a_load      = beat && (state == ST_LOAD_A);
   assign b_load      = beat && (state == ST_LOAD_B);
   assign b_done_beat = b_load && b_final;

   word_packer #(.DATA_W(DATA_W), .OP_W(OP_W)) u_pack_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (a_load),
      .data_in    (s_data),
      .final_beat (a_final),
      .data_out   (a_view)
   );

   word_packer #(.DATA_W(DATA_W), .OP_W(OP_W)) u_pack_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (b_load),
      .data_in    (s_data),
      .final_beat (b_final),
      .data_out   (b_view)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= ST_LOAD_A;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD_A: if (a_load && a_final) state_nxt = ST_LOAD_B;
         ST_LOAD_B: if (b_done_beat)       state_nxt = ST_ISSUE;
         ST_ISSUE:  state_nxt = last_q ? ST_FLUSH : ST_LOAD_A;
         ST_FLUSH:  state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_LOAD_A;
         default:   state_nxt = ST_LOAD_A;
      endcase
   end

   // Handshake and MAC strobes are pure functions of state, so s_ready
   // never depends combinationally on s_valid.
   always_comb begin
      s_ready = 1'b0;
      mac_en  = 1'b0;
      done    = 1'b0;
      case (state)
         ST_LOAD_A, ST_LOAD_B: s_ready = 1'b1;
         ST_ISSUE,  ST_FLUSH:  mac_en  = 1'b1;
         ST_DONE:              done    = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q       <= 1'b0;
         a_out        <= '0;
         b_out        <= '0;
         pair_cnt     <= '0;
         proto_err    <= 1'b0;
         frame_closed <= 1'b0;
      end else begin
         if (b_done_beat) begin
            last_q <= s_last;
            a_out  <= a_view;
            b_out  <= b_view;
         end else if (state == ST_ISSUE && last_q) begin
            a_out <= '0;
            b_out <= '0;
         end

         if (state == ST_ISSUE) begin
            if (pair_cnt != '1)
               pair_cnt <= pair_cnt + 1'b1;
         end else if (beat && frame_closed) begin
            pair_cnt <= '0;
         end

         // The finished frame's total stays visible until the next frame starts.
         if (state == ST_DONE)
            frame_closed <= 1'b1;
         else if (beat)
            frame_closed <= 1'b0;

         if (beat && s_last && !b_done_beat)
            proto_err <= 1'b1;
      end
   end

endmodule

`default_nettype wire
